// File: rtl/fm_capture_pkg.sv
// Shared constants for the FM sample capture engine: state codes, register map,
// CTRL field positions and the latched capture configuration.
package fm_capture_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CAPTURE = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    localparam int STATUS_ADDR = 'h000;
    localparam int CTRL_ADDR   = 'h004;

    localparam int CTRL_START_BIT = 0;
    localparam int CTRL_STOP_BIT  = 1;
    localparam int CTRL_MODE_BIT  = 2;
    localparam int CTRL_DEC_LSB   = 4;
    localparam int DEC_W          = 8;

    localparam int WORD_W = 32;

    typedef struct packed {
        logic             mode;
        logic [DEC_W-1:0] dec;
    } cap_cfg_t;

    // Top byte-address bit of the register bus selects the capture buffer.
    function automatic int buf_sel_bit(input int addr_width);
        return addr_width - 1;
    endfunction

endpackage

// File: rtl/fm_capture_ram.sv
// Simple dual-port buffer: synchronous write, registered read that returns the
// previous contents when reading the word being written in the same cycle.
module fm_capture_ram
    import fm_capture_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [WORD_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [WORD_W-1:0] o_rd_data
);

    logic [WORD_W-1:0] r_mem [DEPTH];
    logic [WORD_W-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        r_rd_data <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/fm_iq_capture.sv
// N-channel ADC capture engine: sequences the ADC mux, decimates by channel set,
// packs sample MSBs into 32-bit words and exposes buffer/status on the register bus.
module fm_iq_capture
    import fm_capture_pkg::*;
#(
    parameter int ADDR_WIDTH  = 13,
    parameter int NUM_CH      = 2,
    parameter int SAMPLE_W    = 12,
    parameter int STORE_W     = 8,
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                                        clk,
    input  logic                                        RSTn,
    input  logic                                        sample_valid,
    input  logic [SAMPLE_W-1:0]                         sample_data,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] ch_sel,
    input  logic [ADDR_WIDTH-1:0]                       wraddr,
    input  logic [31:0]                                 wdata,
    input  logic [3:0]                                  wea,
    input  logic [ADDR_WIDTH-1:0]                       rdaddr,
    output logic [31:0]                                 rdata,
    output logic [1:0]                                  cap_state,
    output logic                                        done_irq
);

    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int LANES   = 32 / STORE_W;
    localparam int LANE_W  = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int PTR_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int BUF_BIT = buf_sel_bit(ADDR_WIDTH);

    logic [1:0]        r_state;
    cap_cfg_t          r_cfg;
    logic [CH_W-1:0]   r_ch;
    logic [LANE_W-1:0] r_lane;
    logic [DEC_W-1:0]  r_dec_cnt;
    logic [PTR_W:0]    r_ptr;
    logic [7:0]        r_wrap;
    logic [31:0]       r_word;
    logic              r_irq;
    logic              r_rd_buf;
    logic [31:0]       r_rd_val;

    logic              w_ctrl_wr;
    logic              w_start;
    logic              w_stop;
    logic              w_take;
    logic              w_set_end;
    logic              w_keep;
    logic              w_last_lane;
    logic              w_ptr_last;
    logic              w_wr_en;
    logic [STORE_W-1:0] w_msb;
    logic [31:0]       w_word_merged;
    logic [31:0]       w_status;
    logic [31:0]       w_ctrl_rb;
    logic [31:0]       w_ram_q;
    logic              w_unused_wdata;

    assign w_ctrl_wr   = (|wea) && (wraddr == ADDR_WIDTH'(CTRL_ADDR));
    assign w_stop      = w_ctrl_wr && wdata[CTRL_STOP_BIT];
    assign w_start     = w_ctrl_wr && wdata[CTRL_START_BIT] && !wdata[CTRL_STOP_BIT];
    // A sample arriving alongside a START/STOP belongs to the old run and is dropped.
    assign w_take      = (r_state == ST_CAPTURE) && sample_valid && !w_start && !w_stop;
    assign w_set_end   = (r_ch == CH_W'(NUM_CH - 1));
    assign w_keep      = (r_dec_cnt == '0);
    assign w_last_lane = (r_lane == LANE_W'(LANES - 1));
    assign w_ptr_last  = (r_ptr[PTR_W-1:0] == PTR_W'(DEPTH_WORDS - 1));
    assign w_wr_en     = w_take && w_keep && w_last_lane;

    assign w_unused_wdata = ^{wdata[31:12], wdata[3]};

    generate
        if (SAMPLE_W >= STORE_W) begin : g_msb_slice
            assign w_msb = sample_data[SAMPLE_W-1 -: STORE_W];
            if (SAMPLE_W > STORE_W) begin : g_lsb_drop
                logic w_unused_lsb;
                assign w_unused_lsb = ^sample_data[SAMPLE_W-STORE_W-1:0];
            end
        end else begin : g_msb_pad
            assign w_msb = {sample_data, {(STORE_W - SAMPLE_W){1'b0}}};
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign w_word_merged[gi*STORE_W +: STORE_W] =
                (r_lane == LANE_W'(gi)) ? w_msb : r_word[gi*STORE_W +: STORE_W];
        end
    endgenerate

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            r_state   <= ST_IDLE;
            r_cfg     <= '0;
            r_ch      <= '0;
            r_lane    <= '0;
            r_dec_cnt <= '0;
            r_ptr     <= '0;
            r_wrap    <= '0;
            r_word    <= '0;
            r_irq     <= 1'b0;
        end else begin
            r_irq <= 1'b0;
            if (w_stop) begin
                r_state <= ST_IDLE;
                r_ch    <= '0;
                r_lane  <= '0;
                r_word  <= '0;
            end else if (w_start) begin
                r_state    <= ST_CAPTURE;
                r_cfg.mode <= wdata[CTRL_MODE_BIT];
                r_cfg.dec  <= wdata[CTRL_DEC_LSB +: DEC_W];
                r_ch       <= '0;
                r_lane     <= '0;
                r_dec_cnt  <= '0;
                r_ptr      <= '0;
                r_wrap     <= '0;
                r_word     <= '0;
            end else if (w_take) begin
                r_ch <= w_set_end ? '0 : r_ch + 1'b1;
                if (w_set_end) begin
                    r_dec_cnt <= (r_dec_cnt >= r_cfg.dec) ? '0 : r_dec_cnt + 1'b1;
                end
                if (w_keep) begin
                    if (w_last_lane) begin
                        r_lane <= '0;
                        r_word <= '0;
                        r_irq  <= w_ptr_last;
                        if (!w_ptr_last) begin
                            r_ptr <= r_ptr + 1'b1;
                        end else if (r_cfg.mode) begin
                            r_ptr  <= '0;
                            r_wrap <= r_wrap + 1'b1;
                        end else begin
                            // One-shot fill: pointer reads back as the word count.
                            r_ptr   <= r_ptr + 1'b1;
                            r_state <= ST_DONE;
                            r_ch    <= '0;
                        end
                    end else begin
                        r_lane <= r_lane + 1'b1;
                        r_word <= w_word_merged;
                    end
                end
            end
        end
    end

    assign w_status  = {16'(r_ptr), r_wrap, 5'b0, r_cfg.mode, r_state};
    assign w_ctrl_rb = 32'({r_cfg.dec, 1'b0, r_cfg.mode, 2'b00});

    fm_capture_ram #(
        .DEPTH  (DEPTH_WORDS),
        .ADDR_W (PTR_W)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_ptr[PTR_W-1:0]),
        .i_wr_data (w_word_merged),
        .i_rd_addr (rdaddr[PTR_W+1:2]),
        .o_rd_data (w_ram_q)
    );

    // Register reads are captured alongside the RAM read so all sources share one cycle of latency.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            r_rd_buf <= 1'b0;
            r_rd_val <= '0;
        end else begin
            r_rd_buf <= rdaddr[BUF_BIT];
            r_rd_val <= '0;
            if (!rdaddr[BUF_BIT]) begin
                if (rdaddr == ADDR_WIDTH'(STATUS_ADDR)) begin
                    r_rd_val <= w_status;
                end else if (rdaddr == ADDR_WIDTH'(CTRL_ADDR)) begin
                    r_rd_val <= w_ctrl_rb;
                end
            end
        end
    end

    assign rdata     = r_rd_buf ? w_ram_q : r_rd_val;
    assign ch_sel    = r_ch;
    assign cap_state = r_state;
    assign done_irq  = r_irq;

endmodule

// File: tb/tb_fm_iq_capture.sv
// Self-checking bench: one 2-channel/8-bit instance and one 3-channel/16-bit instance,
// vector table for the one-shot fill plus hand sequences for the multi-cycle cases.
module tb_fm_iq_capture;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        a_sv;
    logic [11:0] a_sd;
    logic [0:0]  a_ch;
    logic [12:0] a_wraddr;
    logic [31:0] a_wdata;
    logic [3:0]  a_wea;
    logic [12:0] a_rdaddr;
    logic [31:0] a_rdata;
    logic [1:0]  a_state;
    logic        a_irq;

    logic        b_sv;
    logic [15:0] b_sd;
    logic [1:0]  b_ch;
    logic [12:0] b_wraddr;
    logic [31:0] b_wdata;
    logic [3:0]  b_wea;
    logic [12:0] b_rdaddr;
    logic [31:0] b_rdata;
    logic [1:0]  b_state;
    logic        b_irq;

    fm_iq_capture #(
        .ADDR_WIDTH(13), .NUM_CH(2), .SAMPLE_W(12), .STORE_W(8), .DEPTH_WORDS(4)
    ) dut_a (
        .clk(clk), .RSTn(rst_n), .sample_valid(a_sv), .sample_data(a_sd), .ch_sel(a_ch),
        .wraddr(a_wraddr), .wdata(a_wdata), .wea(a_wea), .rdaddr(a_rdaddr), .rdata(a_rdata),
        .cap_state(a_state), .done_irq(a_irq)
    );

    fm_iq_capture #(
        .ADDR_WIDTH(13), .NUM_CH(3), .SAMPLE_W(16), .STORE_W(16), .DEPTH_WORDS(4)
    ) dut_b (
        .clk(clk), .RSTn(rst_n), .sample_valid(b_sv), .sample_data(b_sd), .ch_sel(b_ch),
        .wraddr(b_wraddr), .wdata(b_wdata), .wea(b_wea), .rdaddr(b_rdaddr), .rdata(b_rdata),
        .cap_state(b_state), .done_irq(b_irq)
    );

    int n_chk  = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [11:0] smp;
        int          exp_ch;
        logic        exp_irq;
        logic [1:0]  exp_state;
    } vec_t;
    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
        end
    endtask

    task automatic wr_a(input logic [31:0] d);
        a_wraddr = 13'h004; a_wdata = d; a_wea = 4'hF;
        @(posedge clk); #1;
        a_wea = 4'h0;
        $display("A ctrl write 0x%08h -> state %0d", d, a_state);
    endtask

    task automatic smp_a(input logic [11:0] d);
        a_sv = 1'b1; a_sd = d;
        @(posedge clk); #1;
        a_sv = 1'b0;
        $display("A sample 0x%03h -> state %0d ch_sel %0d irq %0d", d, a_state, a_ch, a_irq);
    endtask

    task automatic rd_a(input logic [12:0] addr, output logic [31:0] d);
        a_rdaddr = addr;
        @(posedge clk); #1;
        d = a_rdata;
        $display("A read 0x%04h -> 0x%08h", addr, d);
    endtask

    task automatic wr_b(input logic [31:0] d);
        b_wraddr = 13'h004; b_wdata = d; b_wea = 4'hF;
        @(posedge clk); #1;
        b_wea = 4'h0;
        $display("B ctrl write 0x%08h -> state %0d", d, b_state);
    endtask

    task automatic smp_b(input logic [15:0] d);
        b_sv = 1'b1; b_sd = d;
        @(posedge clk); #1;
        b_sv = 1'b0;
        $display("B sample 0x%04h -> state %0d ch_sel %0d irq %0d", d, b_state, b_ch, b_irq);
    endtask

    task automatic rd_b(input logic [12:0] addr, output logic [31:0] d);
        b_rdaddr = addr;
        @(posedge clk); #1;
        d = b_rdata;
        $display("B read 0x%04h -> 0x%08h", addr, d);
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] acc;
        logic [31:0] mdl[4];
        logic [7:0]  kept[$];
        logic [11:0] s;
        logic [15:0] sb;
        logic [15:0] prev_b;
        int          irq_cnt;

        rst_n = 1'b0;
        a_sv = 0; a_sd = 0; a_wraddr = 0; a_wdata = 0; a_wea = 0; a_rdaddr = 0;
        b_sv = 0; b_sd = 0; b_wraddr = 0; b_wdata = 0; b_wea = 0; b_rdaddr = 0;
        acc = 0; prev_b = 0;
        for (int i = 0; i < 16; i++) begin
            vecs[i].smp       = 12'((i + 1) << 4);
            vecs[i].exp_ch    = i % 2;
            vecs[i].exp_irq   = (i == 15);
            vecs[i].exp_state = (i == 15) ? 2'd2 : 2'd1;
        end

        repeat (3) @(posedge clk);
        #1;
        check("reset_state", 32'(a_state), 0);
        check("reset_ch_sel", 32'(a_ch), 0);
        check("reset_rdata", a_rdata, 0);
        check("reset_irq", 32'(a_irq), 0);
        rst_n = 1'b1;
        rd_a(13'h000, d);
        check("reset_status", d, 0);

        // One-shot fill of a 4-word buffer
        wr_a(32'h1);
        check("t1_start_state", 32'(a_state), 1);
        irq_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            check("t1_ch_sel", 32'(a_ch), 32'(vecs[i].exp_ch));
            smp_a(vecs[i].smp);
            check("t1_irq", 32'(a_irq), 32'(vecs[i].exp_irq));
            check("t1_state", 32'(a_state), 32'(vecs[i].exp_state));
            if (a_irq) irq_cnt++;
            if (i % 4 == 3) exp_q.push_back(32'h04030201 + 32'h04040404 * 32'(i / 4));
        end
        check("t1_irq_count", 32'(irq_cnt), 1);
        for (int i = 0; i < 2; i++) begin
            smp_a(12'hFFF);
            check("t1_done_hold", 32'(a_state), 2);
            check("t1_done_no_irq", 32'(a_irq), 0);
            check("t1_done_ch0", 32'(a_ch), 0);
        end
        for (int w = 0; w < 4; w++) begin
            rd_a(13'(13'h1000 + w * 4), d);
            check("t1_word", d, exp_q.pop_front());
        end
        rd_a(13'h000, d);
        check("t1_status_lo", 32'(d[15:0]), 32'h0002);

        // Restart from DONE with DEC=1
        wr_a(32'h11);
        rd_a(13'h000, d);
        check("restart_status", d, 32'h0000_0001);
        rd_a(13'h004, d);
        check("ctrl_readback", d, 32'h0000_0010);
        for (int i = 0; i < 16; i++) begin
            s = 12'((i + 1) << 4);
            smp_a(s);
            if (((i / 2) % 2) == 0) kept.push_back(s[11:4]);
        end
        for (int w = 0; w < 2; w++)
            exp_q.push_back({kept[4*w+3], kept[4*w+2], kept[4*w+1], kept[4*w]});
        rd_a(13'h000, d);
        check("dec_status", d, 32'h0002_0001);
        for (int w = 0; w < 2; w++) begin
            rd_a(13'(13'h1000 + w * 4), d);
            check("dec_word", d, exp_q.pop_front());
        end

        // Continuous mode, 40 samples into 4 words
        wr_a(32'h5);
        irq_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            s = 12'($urandom_range(0, 4095));
            acc[(i % 4) * 8 +: 8] = s[11:4];
            if (i == 19) a_rdaddr = 13'h1000;
            smp_a(s);
            check("cont_irq", 32'(a_irq), 32'(((i + 1) % 16) == 0));
            if (a_irq) irq_cnt++;
            if (i == 19) check("rw_same_word_old", a_rdata, mdl[0]);
            if (i == 20) check("rw_same_word_new", a_rdata, mdl[0]);
            if (i % 4 == 3) mdl[(i / 4) % 4] = acc;
        end
        check("cont_irq_count", 32'(irq_cnt), 2);
        rd_a(13'h000, d);
        check("cont_status", d, 32'h0002_0205);
        for (int w = 0; w < 4; w++) exp_q.push_back(mdl[w]);
        for (int w = 0; w < 4; w++) begin
            rd_a(13'(13'h1000 + w * 4), d);
            check("cont_word", d, exp_q.pop_front());
        end

        // STOP after 6 samples
        wr_a(32'h1);
        for (int i = 0; i < 6; i++) begin
            s = 12'(16 * (i + 'h21));
            acc[(i % 4) * 8 +: 8] = s[11:4];
            smp_a(s);
            if (i == 3) exp_q.push_back(acc);
        end
        wr_a(32'h2);
        check("stop_state", 32'(a_state), 0);
        check("stop_ch_sel", 32'(a_ch), 0);
        rd_a(13'h000, d);
        check("stop_status", d, 32'h0001_0000);
        for (int i = 0; i < 4; i++) begin
            smp_a(12'h5A5);
            check("idle_ch_sel", 32'(a_ch), 0);
            check("idle_irq", 32'(a_irq), 0);
        end
        rd_a(13'h000, d);
        check("idle_status", d, 32'h0001_0000);
        rd_a(13'h1000, d);
        check("stop_word0", d, exp_q.pop_front());

        // START and STOP in one write while capturing
        wr_a(32'h1);
        for (int i = 0; i < 3; i++) smp_a(12'h123);
        check("pre_ss_ch_sel", 32'(a_ch), 1);
        wr_a(32'h3);
        check("start_stop_state", 32'(a_state), 0);
        check("start_stop_ch_sel", 32'(a_ch), 0);

        // Reset mid-capture
        wr_a(32'h25);
        for (int i = 0; i < 3; i++) smp_a(12'h321);
        rd_a(13'h000, d);
        check("pre_reset_status", d, 32'h0000_0005);
        check("pre_reset_ch_sel", 32'(a_ch), 1);
        rst_n = 1'b0;
        #2;
        check("rst_state", 32'(a_state), 0);
        check("rst_ch_sel", 32'(a_ch), 0);
        check("rst_rdata", a_rdata, 0);
        check("rst_irq", 32'(a_irq), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rd_a(13'h000, d);
        check("post_rst_status", d, 0);
        rd_a(13'h004, d);
        check("post_rst_ctrl", d, 0);

        // Three channels, 16-bit lanes
        wr_b(32'h1);
        for (int i = 0; i < 8; i++) begin
            check("b_ch_sel", 32'(b_ch), 32'(i % 3));
            sb = 16'($urandom_range(0, 65535));
            smp_b(sb);
            check("b_irq", 32'(b_irq), 32'(i == 7));
            check("b_state", 32'(b_state), (i == 7) ? 32'd2 : 32'd1);
            if (i % 2 == 1) exp_q.push_back({sb, prev_b});
            prev_b = sb;
        end
        check("b_done_ch0", 32'(b_ch), 0);
        for (int w = 0; w < 4; w++) begin
            rd_b(13'(13'h1000 + w * 4), d);
            check("b_word", d, exp_q.pop_front());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
